// File: rtl/blur_window_fetcher.sv
// Fetches 3x3 neighbourhoods from a frame BRAM in raster order and presents each
// window to the blur stage behind a valid/ready handshake, replicating edge pixels.
module blur_window_fetcher #(
  parameter int WIDTH       = 128,
  parameter int HEIGHT      = 128,
  parameter int BIT_DEPTH   = 8,
  parameter int RAM_LATENCY = 2,
  localparam int ADDR_W     = $clog2(WIDTH * HEIGHT),
  localparam int X_W        = $clog2(WIDTH),
  localparam int Y_W        = $clog2(HEIGHT)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  output logic [ADDR_W-1:0]      read_addr_out,
  output logic                   read_en_out,
  input  logic [BIT_DEPTH-1:0]   read_data_in,
  output logic [3*BIT_DEPTH-1:0] r0_data_out,
  output logic [3*BIT_DEPTH-1:0] r1_data_out,
  output logic [3*BIT_DEPTH-1:0] r2_data_out,
  output logic                   data_valid_out,
  input  logic                   ready_in,
  output logic [X_W-1:0]         center_x_out,
  output logic [Y_W-1:0]         center_y_out,
  output logic                   busy_out,
  output logic                   done_out
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]           state;
  logic [3:0]           issue_k;
  logic                 vld_p [RAM_LATENCY];
  logic [3:0]           idx_p [RAM_LATENCY];
  logic [BIT_DEPTH-1:0] win [0:7];
  logic                 cap_vld;
  logic [3:0]           cap_idx;
  logic [X_W-1:0]       next_x;
  logic [Y_W-1:0]       next_y;
  logic                 last_px;

  function automatic int clamp_coord(input int v, input int hi);
    if (v < 0)
      return 0;
    else if (v > hi)
      return hi;
    else
      return v;
  endfunction

  // Tap k of the 3x3 window: dy = k/3-1, dx = k%3-1, clamped into the image.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [X_W-1:0] cx,
                                                 input logic [Y_W-1:0] cy,
                                                 input logic [3:0]     k);
    int tx;
    int ty;
    tx = clamp_coord(int'(cx) + (int'(k) % 3) - 1, WIDTH - 1);
    ty = clamp_coord(int'(cy) + (int'(k) / 3) - 1, HEIGHT - 1);
    return ADDR_W'(ty * WIDTH + tx);
  endfunction

  always_comb begin
    next_x = center_x_out + X_W'(1);
    next_y = center_y_out;
    if (center_x_out == X_W'(WIDTH - 1)) begin
      next_x = '0;
      next_y = center_y_out + Y_W'(1);
    end
  end

  assign last_px = (center_x_out == X_W'(WIDTH - 1)) && (center_y_out == Y_W'(HEIGHT - 1));

  // Stage p0..p(L-1): track which tap each outstanding read belongs to.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RAM_LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= read_en_out;
      for (int i = 1; i < RAM_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    idx_p[0] <= issue_k;
    for (int i = 1; i < RAM_LATENCY; i++) idx_p[i] <= idx_p[i-1];
  end

  assign cap_vld = vld_p[RAM_LATENCY-1];
  assign cap_idx = idx_p[RAM_LATENCY-1];

  // Capture stage: slot 8 bypasses storage and goes straight into the outputs.
  always_ff @(posedge clk_in) begin
    if (cap_vld && cap_idx < 4'd8) win[cap_idx[2:0]] <= read_data_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      issue_k        <= '0;
      read_addr_out  <= '0;
      read_en_out    <= 1'b0;
      r0_data_out    <= '0;
      r1_data_out    <= '0;
      r2_data_out    <= '0;
      data_valid_out <= 1'b0;
      center_x_out   <= '0;
      center_y_out   <= '0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_in) begin
            state         <= S_FETCH;
            busy_out      <= 1'b1;
            center_x_out  <= '0;
            center_y_out  <= '0;
            issue_k       <= '0;
            read_en_out   <= 1'b1;
            read_addr_out <= tap_addr('0, '0, 4'd0);
          end
        end
        S_FETCH: begin
          if (issue_k == 4'd8) begin
            read_en_out <= 1'b0;
            state       <= S_DRAIN;
          end else begin
            issue_k       <= issue_k + 4'd1;
            read_addr_out <= tap_addr(center_x_out, center_y_out, issue_k + 4'd1);
          end
        end
        S_DRAIN: begin
          if (cap_vld && cap_idx == 4'd8) begin
            r0_data_out    <= {win[2], win[1], win[0]};
            r1_data_out    <= {win[5], win[4], win[3]};
            r2_data_out    <= {read_data_in, win[7], win[6]};
            data_valid_out <= 1'b1;
            state          <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (ready_in) begin
            data_valid_out <= 1'b0;
            if (last_px) begin
              state    <= S_DONE;
              done_out <= 1'b1;
            end else begin
              // Next window's first read goes out right behind the handshake.
              center_x_out  <= next_x;
              center_y_out  <= next_y;
              issue_k       <= '0;
              read_en_out   <= 1'b1;
              read_addr_out <= tap_addr(next_x, next_y, 4'd0);
              state         <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy_out <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blur_window_fetcher.sv
// Scoreboard bench for blur_window_fetcher on a 4x4 image whose pixel at address a is a.
module tb_blur_window_fetcher;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int BD  = 8;
  localparam int LAT = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic [3:0]  read_addr_out;
  logic        read_en_out;
  logic [7:0]  read_data_in;
  logic [23:0] r0_data_out;
  logic [23:0] r1_data_out;
  logic [23:0] r2_data_out;
  logic        data_valid_out;
  logic        ready_in;
  logic [1:0]  center_x_out;
  logic [1:0]  center_y_out;
  logic        busy_out;
  logic        done_out;

  blur_window_fetcher #(
    .WIDTH(W), .HEIGHT(H), .BIT_DEPTH(BD), .RAM_LATENCY(LAT)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .read_addr_out(read_addr_out), .read_en_out(read_en_out), .read_data_in(read_data_in),
    .r0_data_out(r0_data_out), .r1_data_out(r1_data_out), .r2_data_out(r2_data_out),
    .data_valid_out(data_valid_out), .ready_in(ready_in),
    .center_x_out(center_x_out), .center_y_out(center_y_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  // BRAM with output register: two cycles from address to data.
  logic [7:0] ram_s1;
  always @(posedge clk_in) begin
    ram_s1       <= read_en_out ? 8'(read_addr_out) : 8'hEE;
    read_data_in <= ram_s1;
  end

  int n_chk = 0;
  int n_fail = 0;
  int rd_count = 0;
  int rd_base = 0;
  int done_count = 0;

  always @(negedge clk_in) begin
    if (read_en_out) rd_count++;
    if (done_out) done_count++;
  end

  typedef struct {
    int         cx;
    int         cy;
    logic [71:0] win;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pix(input int x, input int y);
    int cx;
    int cy;
    cx = (x < 0) ? 0 : (x > W - 1) ? W - 1 : x;
    cy = (y < 0) ? 0 : (y > H - 1) ? H - 1 : y;
    return cy * W + cx;
  endfunction

  function automatic logic [23:0] row_of(input int cx, input int y);
    return {8'(pix(cx + 1, y)), 8'(pix(cx, y)), 8'(pix(cx - 1, y))};
  endfunction

  function automatic logic [71:0] exp_win(input int cx, input int cy);
    return {row_of(cx, cy - 1), row_of(cx, cy), row_of(cx, cy + 1)};
  endfunction

  task automatic push_pass();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        sb.push_back('{cx: x, cy: y, win: exp_win(x, y)});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_addr"},  72'(read_addr_out), 72'(0));
    chk({tag, "_ren"},   72'(read_en_out), 72'(0));
    chk({tag, "_r0"},    72'(r0_data_out), 72'(0));
    chk({tag, "_r1"},    72'(r1_data_out), 72'(0));
    chk({tag, "_r2"},    72'(r2_data_out), 72'(0));
    chk({tag, "_valid"}, 72'(data_valid_out), 72'(0));
    chk({tag, "_cx"},    72'(center_x_out), 72'(0));
    chk({tag, "_cy"},    72'(center_y_out), 72'(0));
    chk({tag, "_busy"},  72'(busy_out), 72'(0));
    chk({tag, "_done"},  72'(done_out), 72'(0));
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (!data_valid_out && cyc < budget) begin
      @(posedge clk_in); #1;
      cyc++;
    end
    chk("valid_arrives", 72'(data_valid_out), 72'(1));
  endtask

  task automatic start_pass();
    push_pass();
    rd_base  = rd_count;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    chk("start_ren",  72'(read_en_out), 72'(1));
    chk("start_addr", 72'(read_addr_out), 72'(0));
    chk("start_busy", 72'(busy_out), 72'(1));
  endtask

  // Called one cycle after start; walks windows until stop_w, optionally
  // stalling one window and poking start_in in the middle of the pass.
  task automatic run_pass(input int stall_w, input int poke_w, input int stop_w);
    int pre;
    int cyc;
    exp_t e;
    logic [71:0] snap_win;
    logic [71:0] snap_ctl;
    pre = 1;
    for (int w = 0; w < W * H; w++) begin
      if (w == stop_w) return;
      ready_in = (w != stall_w);
      wait_valid(60, cyc);
      chk("latency", 72'(pre + cyc), 72'(12));
      chk("reads_per_window", 72'(rd_count - rd_base), 72'(9));
      if (sb.size() == 0) begin
        chk("sb_underflow", 72'(1), 72'(0));
      end else begin
        e = sb.pop_front();
        chk("centre_x", 72'(center_x_out), 72'(e.cx));
        chk("centre_y", 72'(center_y_out), 72'(e.cy));
        chk("window", {r0_data_out, r1_data_out, r2_data_out}, e.win);
      end
      if (w == 0)
        chk("corner_00", {r0_data_out, r1_data_out, r2_data_out},
            {24'h010000, 24'h010000, 24'h050404});
      if (w == 5)
        chk("interior_11", {r0_data_out, r1_data_out, r2_data_out},
            {24'h020100, 24'h060504, 24'h0A0908});
      if (w == 15)
        chk("corner_33", {r0_data_out, r1_data_out, r2_data_out},
            {24'h0B0B0A, 24'h0F0F0E, 24'h0F0F0E});
      if (w == stall_w) begin
        snap_win = {r0_data_out, r1_data_out, r2_data_out};
        snap_ctl = 72'({read_addr_out, center_x_out, center_y_out, busy_out, done_out});
        repeat (5) begin
          @(posedge clk_in); #1;
          chk("stall_valid", 72'(data_valid_out), 72'(1));
          chk("stall_noread", 72'(read_en_out), 72'(0));
          chk("stall_window", {r0_data_out, r1_data_out, r2_data_out}, snap_win);
          chk("stall_ctl",
              72'({read_addr_out, center_x_out, center_y_out, busy_out, done_out}), snap_ctl);
        end
        ready_in = 1'b1;
      end
      rd_base = rd_count;
      @(posedge clk_in); #1;
      if (w < W * H - 1) begin
        chk("next_fetch", 72'(read_en_out), 72'(1));
        pre = 1;
        if (w == poke_w) begin
          start_in = 1'b1;
          @(posedge clk_in); #1;
          start_in = 1'b0;
          pre = 2;
        end
      end
    end
    chk("done_pulse",  72'(done_out), 72'(1));
    chk("done_busy",   72'(busy_out), 72'(1));
    chk("done_valid",  72'(data_valid_out), 72'(0));
    chk("done_noread", 72'(read_en_out), 72'(0));
    @(posedge clk_in); #1;
    chk("after_done",  72'(done_out), 72'(0));
    chk("after_busy",  72'(busy_out), 72'(0));
    chk("sb_empty",    72'(sb.size()), 72'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    rst_in   = 1'b1;
    start_in = 1'b0;
    ready_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_reset("por");
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_reset("idle");

    // Full pass: backpressure on window (1,1), stray start during window 8 fetch.
    d0 = done_count;
    start_pass();
    run_pass(5, 7, W * H);
    repeat (10) @(posedge clk_in);
    #1;
    chk("done_count", 72'(done_count - d0), 72'(1));
    chk("idle_after_pass", 72'(busy_out), 72'(0));

    // Reset while fetching centre (2,1), then restart from the origin.
    start_pass();
    run_pass(-1, -1, 6);
    chk("pre_rst_cx",  72'(center_x_out), 72'(2));
    chk("pre_rst_cy",  72'(center_y_out), 72'(1));
    chk("pre_rst_ren", 72'(read_en_out), 72'(1));
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    check_reset("midrst");
    d0 = done_count;
    repeat (6) @(posedge clk_in);
    #1;
    chk("rst_idle_busy",  72'(busy_out), 72'(0));
    chk("rst_idle_ren",   72'(read_en_out), 72'(0));
    chk("rst_idle_valid", 72'(data_valid_out), 72'(0));
    chk("rst_no_done",    72'(done_count - d0), 72'(0));
    sb.delete();
    start_pass();
    run_pass(-1, -1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
